// File: rtl/prra_arbiter_if.sv
// rtl/prra_arbiter_if.sv - request/grant bundle between requesters and the round-robin lock arbiter
interface prra_arbiter_if #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = 2
);
  logic [WIDTH-1:0]      request;
  logic [WIDTH-1:0]      grant;
  logic                  grant_valid;
  logic [LOG2_WIDTH-1:0] grant_id;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/prra_arbiter.sv
// rtl/prra_arbiter.sv - round-robin lock arbiter; optional owner hold timeout under macro PRRA_TIMEOUT_EN
module prra_arbiter #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  prra_arbiter_if.slave bus
);

  if (WIDTH < 2 || MAX_HOLD < 1 || LOG2_WIDTH != $clog2(WIDTH)) begin : g_bad_params
    $error("prra_arbiter: illegal WIDTH/LOG2_WIDTH/MAX_HOLD combination");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [WIDTH-1:0]      grant_q;
  logic                  grant_valid_q;
  logic [LOG2_WIDTH-1:0] grant_id_q;
  logic [LOG2_WIDTH-1:0] ptr;

  logic [LOG2_WIDTH-1:0] winner;
  logic [LOG2_WIDTH-1:0] cand;
  logic [WIDTH-1:0]      winner_onehot;
  logic                  have_others;
  logic                  expire;
  int                    idx;

`ifdef PRRA_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;
  // hold_cnt counts completed held cycles, so the owner is displaced on the edge ending its MAX_HOLD-th cycle
  assign expire = (hold_cnt >= CW'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  // Search from ptr+1 upward with wrap; walking from the far end lets the nearest hit overwrite.
  // While LOCKED ptr equals the owner, so the owner is naturally the last candidate.
  always_comb begin
    winner = ptr;
    idx    = 0;
    cand   = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      cand = LOG2_WIDTH'(idx);
      if (bus.request[cand]) winner = cand;
    end
    winner_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << winner;
    have_others   = |(bus.request & ~grant_q);
  end

  // Single FSM: IDLE/LOCKED with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr           <= LOG2_WIDTH'(WIDTH - 1);
`ifdef PRRA_TIMEOUT_EN
      hold_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.request) begin
            state         <= LOCKED;
            grant_q       <= winner_onehot;
            grant_valid_q <= 1'b1;
            grant_id_q    <= winner;
            ptr           <= winner;
`ifdef PRRA_TIMEOUT_EN
            hold_cnt      <= '0;
`endif
          end
        end
        LOCKED: begin
          if (bus.request[grant_id_q] && !(expire && have_others)) begin
`ifdef PRRA_TIMEOUT_EN
            if (hold_cnt != CW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
`endif
          end else if (have_others) begin
            grant_q    <= winner_onehot;
            grant_id_q <= winner;
            ptr        <= winner;
`ifdef PRRA_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
          end else begin
            state         <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
`ifdef PRRA_TIMEOUT_EN
            hold_cnt      <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_prra_arbiter.sv
// tb/tb_prra_arbiter.sv - self-checking bench for prra_arbiter against a behavioural owner/pointer model
module tb_prra_arbiter;
  localparam int W  = 4;
  localparam int LW = 2;
  localparam int MH = 4;
`ifdef PRRA_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  prra_arbiter_if #(.WIDTH(W), .LOG2_WIDTH(LW)) bus ();

  prra_arbiter #(.WIDTH(W), .LOG2_WIDTH(LW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: owner (-1 = none), last-owner pointer, reported id, cycles the owner has been visible
  typedef struct packed {
    int owner;
    int ptr;
    int id;
    int held;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.owner = -1;
    s.ptr   = W - 1;
    s.id    = 0;
    s.held  = 0;
    return s;
  endfunction

  // First set bit of r when scanning from ptr+1 with wrap: rotate a doubled copy and take the lowest one
  function automatic int pick(logic [W-1:0] r, int ptr);
    logic [2*W-1:0] dbl;
    dbl = {r, r} >> (ptr + 1);
    for (int p = 0; p < W; p++) if (dbl[p]) return (ptr + 1 + p) % W;
    return -1;
  endfunction

  function automatic mstate_t model_next(mstate_t s, logic [W-1:0] r);
    mstate_t    n;
    logic [W-1:0] others;
    int         w;
    n = s;
    if (s.owner < 0) begin
      if (r != '0) begin
        w = pick(r, s.ptr);
        n.owner = w; n.ptr = w; n.id = w; n.held = 1;
      end
    end else begin
      others = r;
      others[s.owner] = 1'b0;
      if (r[s.owner] && !(TO && s.held >= MH && others != '0)) begin
        n.held = s.held + 1;
      end else if (others != '0) begin
        w = pick(others, s.owner);
        n.owner = w; n.ptr = w; n.id = w; n.held = 1;
      end else begin
        n.owner = -1;
        n.held  = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [W-1:0] exp_grant(mstate_t s);
    logic [W-1:0] g;
    g = '0;
    if (s.owner >= 0) g[s.owner] = 1'b1;
    return g;
  endfunction

  // Model state advances on the same edges as the DUT, including asynchronous reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= reset_state();
    else        ms <= model_next(ms, bus.request);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic lit(input string name, input logic [W-1:0] g, input logic v, input int id);
    check({name, ".grant"}, 32'(bus.grant), 32'(g));
    check({name, ".valid"}, 32'(bus.grant_valid), 32'(v));
    check({name, ".id"}, 32'(bus.grant_id), 32'(id));
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cyc.grant", 32'(bus.grant), 32'(exp_grant(ms)));
    check("cyc.valid", 32'(bus.grant_valid), 32'(ms.owner >= 0));
    check("cyc.id", 32'(bus.grant_id), 32'(ms.id));
  end

  task automatic drive(input logic [W-1:0] r);
    bus.request = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 lit("async_reset_drop", 4'b0000, 1'b0, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] pat [3];
    bus.request = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    lit("reset_state", 4'b0000, 1'b0, 0);
    rst_n = 1'b1;

    drive(4'b0001); lit("first_grant", 4'b0001, 1'b1, 0);
    drive(4'b0010); lit("handover_to_1", 4'b0010, 1'b1, 1);
    drive(4'b1011); lit("owner1_holds", 4'b0010, 1'b1, 1);
    drive(4'b1001); lit("handover_to_3", 4'b1000, 1'b1, 3);
    drive(4'b0001); lit("wrap_to_0", 4'b0001, 1'b1, 0);

    drive(4'b1111); lit("rot_hold0", 4'b0001, 1'b1, 0);
    drive(4'b1110); lit("rot_1", 4'b0010, 1'b1, 1);
    drive(4'b1101); lit("rot_2", 4'b0100, 1'b1, 2);
    drive(4'b1011); lit("rot_3", 4'b1000, 1'b1, 3);
    drive(4'b0111); lit("rot_0", 4'b0001, 1'b1, 0);

    drive(4'b0100); lit("owner2", 4'b0100, 1'b1, 2);
    drive(4'b0000); lit("to_idle_keep_id", 4'b0000, 1'b0, 2);
    drive(4'b0110); lit("search_from_3", 4'b0010, 1'b1, 1);

    pat[0] = 4'b1111; pat[1] = 4'b0011; pat[2] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      drive(pat[i]); lit("others_ignored", 4'b0010, 1'b1, 1);
    end

    drive(4'b0100); lit("owner2_again", 4'b0100, 1'b1, 2);
    reset_pulse();
    drive(4'b0100); lit("after_reset_0100", 4'b0100, 1'b1, 2);
    reset_pulse();
    drive(4'b1111); lit("after_reset_1111", 4'b0001, 1'b1, 0);

    reset_pulse();
    for (int k = 0; k < 12; k++) begin
      drive(4'b0011);
      if (TO && ((k / MH) % 2 == 1)) lit("hold_0011", 4'b0010, 1'b1, 1);
      else                           lit("hold_0011", 4'b0001, 1'b1, 0);
    end
    repeat (6) drive(4'b0001);
    drive(4'b0011);
    if (TO) lit("saturated_then_other", 4'b0010, 1'b1, 1);
    else    lit("saturated_then_other", 4'b0001, 1'b1, 0);

    r = '0;
    for (int i = 0; i < 240; i++) begin
      if (i % 3 == 0) r = W'($urandom_range(0, (1 << W) - 1));
      drive(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prra_arbiter.md
PRRA_ARBITER -- requirements
Module: prra_arbiter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of requesters (>=2).
REQ-002 SHALL provide parameter LOG2_WIDTH, default 2, width of the grant index; SHALL equal ceil(log2(WIDTH)).
REQ-003 SHALL provide parameter MAX_HOLD, default 16, maximum consecutive locked cycles when PRRA_TIMEOUT_EN is defined (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 request  input  WIDTH  per-requester request level; bit i high = requester i wants or holds the resource.
REQ-007 grant  output  WIDTH  one-hot grant, registered; all-zero when no owner.
REQ-008 grant_valid  output  1  high when exactly one grant bit is set.
REQ-009 grant_id  output  LOG2_WIDTH  index of current owner; holds last owner when grant_valid low.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and LOCKED (owner = grant_id).
REQ-011 SHALL keep a last-owner pointer; search order each arbitration = (pointer+1) mod WIDTH, ascending, wrapping, pointer checked last.
REQ-012 IDLE, request all-zero: SHALL stay IDLE; grant stays zero.
REQ-013 IDLE, request non-zero: SHALL go LOCKED at next edge with grant = first set bit in search order (latency 1 cycle); pointer and grant_id SHALL update to winner.
REQ-014 LOCKED, request[grant_id]=1: SHALL hold grant unchanged (subject to REQ-021).
REQ-015 LOCKED, request[grant_id]=0, other bits set: SHALL hand over directly at next edge to next winner in search order; no idle bubble.
REQ-016 LOCKED, request all-zero: SHALL go IDLE at next edge; grant zero; pointer retained.
REQ-017 Owner's deasserting requester SHALL never be re-granted in the same handover cycle unless it is the only requester and has re-raised request.
REQ-018 Pointer arithmetic SHALL be modulo WIDTH for non-power-of-two WIDTH; indices >= WIDTH never produced.
REQ-019 Bits of request changing while LOCKED other than owner's SHALL not affect grant.
REQ-020 grant and grant_id SHALL be driven from flops only (no combinational path from request).

Reset
REQ-021 (see REQ-025) hold counter SHALL reset to 0.
REQ-022 On rst_n low: FSM = IDLE, grant = 0, grant_valid = 0, grant_id = 0, pointer = WIDTH-1 (so requester 0 has first priority after reset).
REQ-023 Reset asserted mid-grant SHALL drop grant immediately (asynchronous), without waiting for clk.
REQ-024 First arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro PRRA_TIMEOUT_EN: when defined, SHALL count consecutive LOCKED cycles of one owner; when count reaches MAX_HOLD and any other request bit is set, SHALL hand over at next edge as in REQ-015 (owner treated as lowest priority), counter cleared on any grant change; if no other requester, owner keeps grant and counter saturates at MAX_HOLD.
REQ-026 Without PRRA_TIMEOUT_EN: no counter logic; owner holds indefinitely while request[grant_id]=1.

Verification (WIDTH=4, MAX_HOLD=4)
REQ-027 Reset release, request=0001 -> next edge grant=0001, grant_id=0, grant_valid=1.
REQ-028 Owner 1 holding, request=1011 then 1001 -> grant moves to 1000 (id 3) one edge after owner drops; then request=0001 -> grant 0001 (wrap).
REQ-029 request=1111 with owner dropping each cycle in turn -> grant sequence 0001,0010,0100,1000,0001 (fair rotation).
REQ-030 LOCKED owner 2, request->0000 -> grant=0000, grant_valid=0 next edge, grant_id stays 2; then request=0110 -> grant 0010? no: search from 3 -> grant=0010 only if bits 3,0 clear: expected grant=0010.
REQ-031 rst_n pulsed low between edges while grant=0100 -> grant=0000 immediately; after release, request=0100 -> grant=0100, pointer restarted (request=1111 -> 0001 wins).
REQ-032 PRRA_TIMEOUT_EN defined, request=0011 held constant -> grant 0001 for 4 cycles then 0010 for 4 cycles, alternating; without macro grant stays 0001 indefinitely.
